emu_scan_ctrl: RTL and testbench
================================

EMU_SCAN_CTRL -- requirements
Module: emu_scan_ctrl

Interface
REQ-001 Parameter FF_WORDS, default 4, number of 64-bit words in the FF scan chain.
REQ-002 Parameter MEM_WORDS, default 16, number of 64-bit words in the RAM scan chain.
REQ-003 clk  input  1  single clock; all state in this block is clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid/cmd_ready  input/output  1/1  checkpoint command handshake.
REQ-006 cmd_dir  input  1  0 = dump (DUT to host), 1 = restore (host to DUT); sampled on cmd handshake.
REQ-007 pause  output  1  freezes DUT functional clocks (drives clock-gate enables).
REQ-008 ff_se, ff_dir  output  1 each  FF chain scan enable and direction.
REQ-009 ff_di  output  64  FF chain input; equals ff_do when ff_dir=0 (loop-back), else restore word.
REQ-010 ff_do  input  64  FF chain output.
REQ-011 ram_se, ram_sd  output  1 each  RAM chain scan enable and direction.
REQ-012 ram_di  output  64; ram_do  input  64  RAM chain data.
REQ-013 dout_valid/dout_ready/dout_data  out/in/out  1/1/64  dump word stream to host.
REQ-014 din_valid/din_ready/din_data  in/out/in  1/1/64  restore word stream from host.
REQ-015 busy  output  1  high from command accept until return to IDLE; done output 1 one-cycle pulse on completion.

Function
REQ-016 States SHALL be IDLE, PAUSE, FF_SCAN, RAM_PRIME, RAM_SCAN, RAM_TAIL, SETTLE.
REQ-017 IDLE: cmd_ready=1, pause=0, all scan enables 0; cmd handshake latches cmd_dir and moves to PAUSE.
REQ-018 PAUSE: pause=1 for exactly one cycle, no scan enable, then FF_SCAN.
REQ-019 pause SHALL stay 1 in every state from PAUSE through SETTLE inclusive.
REQ-020 ff_dir, ram_sd SHALL equal the latched cmd_dir throughout busy.
REQ-021 FF_SCAN dump: ff_se=1 only in cycles where the output FIFO is not full; ff_do captured into FIFO in each such cycle; ff_se=0 stalls the chain.
REQ-022 FF_SCAN restore: ff_se=din_ready=din_valid; ff_di=din_data; one word consumed per handshake.
REQ-023 FF_SCAN ends after FF_WORDS transfers; next state RAM_PRIME (dump) or RAM_SCAN (restore).
REQ-024 RAM_PRIME: ram_se=1 for exactly 2 cycles, no capture (RAM chain read latency 2).
REQ-025 RAM_SCAN dump: ram_se=1 only when FIFO not full; ram_do captured each ram_se=1 cycle; MEM_WORDS captures then SETTLE.
REQ-026 RAM_SCAN restore: ram_se=din_ready=din_valid; ram_di=din_data; after MEM_WORDS words go to RAM_TAIL.
REQ-027 RAM_TAIL: ram_se=1, ram_di=0 for exactly one cycle, then SETTLE.
REQ-028 SETTLE: all scan enables 0, pause=1 for one cycle; dump additionally waits until FIFO empty; then done=1 for one cycle, pause=0, return to IDLE.
REQ-029 Output FIFO: 2 entries, dout_valid=not empty, pop on dout_valid&&dout_ready, push and pop same cycle allowed when not full.
REQ-030 Word order on dout SHALL be FF words 0..FF_WORDS-1 then RAM words 0..MEM_WORDS-1; restore consumes the same order.
REQ-031 Word counters SHALL be sized clog2(max(FF_WORDS,MEM_WORDS)+1) and cleared on every state change.
REQ-032 din_ready=0 outside restore FF_SCAN/RAM_SCAN; cmd_valid while busy SHALL be ignored (cmd_ready=0).
REQ-033 When ff_se=0, ff_di SHALL equal ff_do; when ram_se=0, ram_di SHALL be 0.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, empty FIFO, zero counters; outputs pause, ff_se, ff_dir, ram_se, ram_sd, dout_valid, din_ready, busy, done =0; cmd_ready=1 after deassertion.
REQ-035 Reset mid-checkpoint SHALL abort with no further scan enable pulses; the DUT chain state is then undefined.

Verification (FF_WORDS=3, MEM_WORDS=10)
REQ-036 Dump, dout_ready=1 always: pause rises 1 cycle after accept; ff_se high 3 cycles, ram_se 12 cycles; 13 words out in chain order; done 1 cycle; pause total 18 cycles.
REQ-037 Dump with dout_ready toggling 1/0 each cycle: ff_se/ram_se drop while FIFO full; word sequence identical to REQ-036, no loss or duplicates.
REQ-038 Restore, din_valid=1 always, words 0x1..0xD: ff_se high 3 cycles with ff_di=1,2,3; ram_di=4..0xD over 10 cycles, then one ram_se tail cycle with ram_di=0; done pulse.
REQ-039 Restore with din_valid gaps: ff_se/ram_se low exactly in gap cycles; no word skipped.
REQ-040 Round trip on sim DUT: dump, overwrite memory, restore dumped stream -> DUT registers and all memory words match pre-dump values.
REQ-041 rst asserted during RAM_SCAN: all outputs zero same cycle; after release cmd_ready=1 and a new dump completes normally.

Source files
------------

// File: rtl/emu_scan_ctrl.sv
// Checkpoint scan controller. It freezes the emulated design, then streams the FF and
// RAM scan chains to the host (dump) or loads them back from the host (restore).
module emu_scan_ctrl #(
  parameter int FF_WORDS  = 4,
  parameter int MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  output logic        pause,
  output logic        ff_se,
  output logic        ff_dir,
  output logic [63:0] ff_di,
  input  logic [63:0] ff_do,
  output logic        ram_se,
  output logic        ram_sd,
  output logic [63:0] ram_di,
  input  logic [63:0] ram_do,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [63:0] dout_data,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [63:0] din_data,
  output logic        busy,
  output logic        done
);

  localparam int MAX_WORDS = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
  localparam int CW        = $clog2(MAX_WORDS + 1);

  localparam logic [CW-1:0] FF_LAST    = CW'(FF_WORDS - 1);
  localparam logic [CW-1:0] MEM_LAST   = CW'(MEM_WORDS - 1);
  localparam logic [CW-1:0] PRIME_LAST = CW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PAUSE     = 3'd1;
  localparam logic [2:0] FF_SCAN   = 3'd2;
  localparam logic [2:0] RAM_PRIME = 3'd3;
  localparam logic [2:0] RAM_SCAN  = 3'd4;
  localparam logic [2:0] RAM_TAIL  = 3'd5;
  localparam logic [2:0] SETTLE    = 3'd6;

  logic [2:0]    state, next_state;
  logic          dir_q;
  logic [CW-1:0] cnt;
  logic          xfer;

  logic [63:0]   fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [63:0]   push_data;

  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign pop        = dout_valid && dout_ready;

  assign busy       = (state != IDLE);
  assign pause      = busy;
  assign ff_dir     = busy && dir_q;
  assign ram_sd     = busy && dir_q;
  assign cmd_ready  = (state == IDLE) && !rst;
  assign dout_valid = !fifo_empty;
  assign dout_data  = fifo_mem[rd_ptr];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    ff_se      = 1'b0;
    ram_se     = 1'b0;
    din_ready  = 1'b0;
    ff_di      = ff_do;
    ram_di     = '0;
    push       = 1'b0;
    push_data  = ff_do;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) next_state = PAUSE;
      end
      PAUSE: next_state = FF_SCAN;
      FF_SCAN: begin
        if (dir_q) begin
          ff_se     = din_valid;
          din_ready = din_valid;
          ff_di     = din_valid ? din_data : ff_do;
          xfer      = din_valid;
        end else begin
          // The FF chain only shifts when its word has somewhere to go.
          ff_se = !fifo_full;
          push  = !fifo_full;
          xfer  = !fifo_full;
        end
        if (xfer && cnt == FF_LAST) next_state = dir_q ? RAM_SCAN : RAM_PRIME;
      end
      RAM_PRIME: begin
        ram_se = 1'b1;
        if (cnt == PRIME_LAST) next_state = RAM_SCAN;
      end
      RAM_SCAN: begin
        if (dir_q) begin
          ram_se    = din_valid;
          din_ready = din_valid;
          ram_di    = din_valid ? din_data : 64'd0;
          xfer      = din_valid;
        end else begin
          ram_se    = !fifo_full;
          push      = !fifo_full;
          push_data = ram_do;
          xfer      = !fifo_full;
        end
        if (xfer && cnt == MEM_LAST) next_state = dir_q ? RAM_TAIL : SETTLE;
      end
      RAM_TAIL: begin
        // Flushes the RAM chain's write pipeline with a zero word.
        ram_se     = 1'b1;
        next_state = SETTLE;
      end
      SETTLE: begin
        if (dir_q || fifo_empty) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dir_q <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (state == SETTLE) && (next_state == IDLE);
      if (cmd_valid && cmd_ready) dir_q <= cmd_dir;
      if (state != next_state)                cnt <= '0;
      else if (xfer || state == RAM_PRIME)    cnt <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; occupancy is, so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_emu_scan_ctrl.sv
// Self-checking bench for emu_scan_ctrl with behavioural FF and RAM scan chains
// standing in for the emulated design.
module tb_emu_scan_ctrl;
  localparam int FFW = 3;
  localparam int MW  = 10;
  localparam int NW  = FFW + MW;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic        pause, ff_se, ff_dir, ram_se, ram_sd;
  logic [63:0] ff_di, ff_do, ram_di, ram_do;
  logic        dout_valid, dout_ready, din_valid, din_ready;
  logic [63:0] dout_data, din_data;
  logic        busy, done;

  always #5 clk = ~clk;

  emu_scan_ctrl #(.FF_WORDS(FFW), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .pause(pause), .ff_se(ff_se), .ff_dir(ff_dir), .ff_di(ff_di), .ff_do(ff_do),
    .ram_se(ram_se), .ram_sd(ram_sd), .ram_di(ram_di), .ram_do(ram_do),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  // Emulated target: FF shift chain and a RAM chain with 2-cycle read / 1-cycle write latency.
  logic [63:0] ff_chain [FFW];
  logic [63:0] mem      [MW];
  logic [63:0] ff_init  [FFW];
  logic [63:0] mem_init [MW];
  logic        model_load = 1'b0;
  logic [63:0] rd_s1, rd_s2, wbuf;
  logic [3:0]  rptr, wptr;
  logic        wfull;

  assign ff_do  = ff_chain[0];
  assign ram_do = rd_s2;

  always @(posedge clk) begin
    if (model_load) begin
      for (int i = 0; i < FFW; i++) ff_chain[i] <= ff_init[i];
      for (int i = 0; i < MW; i++)  mem[i]      <= mem_init[i];
    end else begin
      if (ff_se) begin
        for (int i = 0; i < FFW - 1; i++) ff_chain[i] <= ff_chain[i+1];
        ff_chain[FFW-1] <= ff_di;
      end
      if (cmd_valid && cmd_ready) begin
        rptr  <= 4'd0;
        wptr  <= 4'd0;
        wfull <= 1'b0;
      end else if (ram_se && !ram_sd) begin
        rd_s1 <= mem[rptr];
        rd_s2 <= rd_s1;
        rptr  <= (rptr == 4'(MW - 1)) ? 4'd0 : rptr + 4'd1;
      end else if (ram_se && ram_sd) begin
        if (wfull) begin
          mem[wptr] <= wbuf;
          wptr      <= (wptr == 4'(MW - 1)) ? 4'd0 : wptr + 4'd1;
        end
        wbuf  <= ram_di;
        wfull <= 1'b1;
      end
    end
  end

  logic [63:0] cur_ff  [FFW];
  logic [63:0] cur_mem [MW];
  logic [63:0] stream  [NW];
  logic [63:0] got     [NW];
  logic [63:0] sb [$];
  int n_pause, n_ff, n_ram, n_tail, n_done, n_got;

  task automatic load_model(input bit seq, input logic [63:0] base);
    for (int i = 0; i < FFW; i++) ff_init[i]  = seq ? base + 64'(i) : {$urandom, $urandom};
    for (int i = 0; i < MW; i++)  mem_init[i] = seq ? base + 64'(FFW + i) : {$urandom, $urandom};
    cur_ff  = ff_init;
    cur_mem = mem_init;
    @(negedge clk); model_load = 1'b1;
    @(negedge clk); model_load = 1'b0;
  endtask

  // Drives one checkpoint command and checks every cycle against the scoreboard.
  task automatic run_checkpoint(input bit dir, input int rdy_mode, input int vld_mode);
    int  idx = 0;
    bit  finished = 0;
    logic [63:0] exp_w;
    sb.delete();
    if (!dir) begin
      for (int i = 0; i < FFW; i++) sb.push_back(cur_ff[i]);
      for (int i = 0; i < MW; i++)  sb.push_back(cur_mem[i]);
    end else begin
      for (int i = 0; i < NW; i++)  sb.push_back(stream[i]);
    end
    n_pause = 0; n_ff = 0; n_ram = 0; n_tail = 0; n_done = 0; n_got = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = dir;
    #1;
    total++; if (cmd_ready !== 1'b1 || pause !== 1'b0) begin bad++; $display("FAIL cmd_accept: ready=%b pause=%b want 1/0", cmd_ready, pause); end
    @(negedge clk);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      dout_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 0);
      din_valid  = dir && idx < NW && (vld_mode == 0 || cyc % 3 != 1);
      din_data   = din_valid ? stream[idx] : 64'hBAD0_BAD0_BAD0_BAD0;
      cmd_valid  = (cyc >= 2 && cyc < 6);
      cmd_dir    = !dir;
      #1;
      if (pause)  n_pause++;
      if (ff_se)  n_ff++;
      if (ram_se) n_ram++;
      if (cyc == 0) begin
        total++; if (pause !== 1'b1) begin bad++; $display("FAIL pause_rise: got %b want 1", pause); end
      end
      total++; if (pause !== busy) begin bad++; $display("FAIL pause_busy: pause=%b busy=%b", pause, busy); end
      if (busy) begin
        total++; if (ff_dir !== dir || ram_sd !== dir) begin bad++; $display("FAIL dir_latch: ff_dir=%b ram_sd=%b want %b", ff_dir, ram_sd, dir); end
      end
      if (cmd_valid) begin
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL cmd_ignored: cmd_ready=%b want 0", cmd_ready); end
      end
      if (!ff_se) begin
        total++; if (ff_di !== ff_do) begin bad++; $display("FAIL ff_loopback: ff_di=%h want %h", ff_di, ff_do); end
      end
      if (!ram_se) begin
        total++; if (ram_di !== 64'd0) begin bad++; $display("FAIL ram_di_idle: got %h want 0", ram_di); end
      end
      if (!dir) begin
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL din_ready_dump: got %b want 0", din_ready); end
      end
      if (dir && idx < NW && !din_valid) begin
        total++; if (ff_se !== 1'b0 || ram_se !== 1'b0) begin bad++; $display("FAIL gap_stall: ff_se=%b ram_se=%b want 0/0", ff_se, ram_se); end
      end
      if (dir && ff_se) begin
        exp_w = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        total++; if (ff_di !== exp_w) begin bad++; $display("FAIL restore_ff_di: got %h want %h", ff_di, exp_w); end
      end
      if (dir && ram_se) begin
        if (sb.size() > 0) begin
          exp_w = sb.pop_front();
          total++; if (ram_di !== exp_w) begin bad++; $display("FAIL restore_ram_di: got %h want %h", ram_di, exp_w); end
        end else begin
          n_tail++;
          total++; if (ram_di !== 64'd0) begin bad++; $display("FAIL tail_ram_di: got %h want 0", ram_di); end
        end
      end
      if (dir && din_valid && din_ready) idx++;
      if (dout_valid && dout_ready) begin
        exp_w = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        if (n_got < NW) got[n_got] = dout_data;
        n_got++;
        total++; if (dout_data !== exp_w) begin bad++; $display("FAIL dump_word%0d: got %h want %h", n_got - 1, dout_data, exp_w); end
      end
      if (done) begin
        n_done++;
        finished = 1;
        total++; if (pause !== 1'b0) begin bad++; $display("FAIL done_pause: pause=%b want 0", pause); end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    #1;
    total++; if (!finished) begin bad++; $display("FAIL timeout: done never seen, want done pulse"); end
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_one_cycle: done=%b busy=%b want 0/0", done, busy); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
  endtask

  task automatic check_counts(input string name, input int ff_exp, input int ram_exp,
                              input int tail_exp, input int got_exp, input int pause_exp);
    total++; if (n_ff !== ff_exp) begin bad++; $display("FAIL %s_ff_se: got %0d want %0d", name, n_ff, ff_exp); end
    total++; if (n_ram !== ram_exp) begin bad++; $display("FAIL %s_ram_se: got %0d want %0d", name, n_ram, ram_exp); end
    total++; if (n_tail !== tail_exp) begin bad++; $display("FAIL %s_tail: got %0d want %0d", name, n_tail, tail_exp); end
    total++; if (n_got !== got_exp) begin bad++; $display("FAIL %s_words: got %0d want %0d", name, n_got, got_exp); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL %s_done: got %0d want 1", name, n_done); end
    if (pause_exp > 0) begin
      total++; if (n_pause !== pause_exp) begin bad++; $display("FAIL %s_pause: got %0d want %0d", name, n_pause, pause_exp); end
    end
  endtask

  task automatic check_target(input string name);
    for (int i = 0; i < FFW; i++) begin
      total++; if (ff_chain[i] !== cur_ff[i]) begin bad++; $display("FAIL %s_ff%0d: got %h want %h", name, i, ff_chain[i], cur_ff[i]); end
    end
    for (int i = 0; i < MW; i++) begin
      total++; if (mem[i] !== cur_mem[i]) begin bad++; $display("FAIL %s_mem%0d: got %h want %h", name, i, mem[i], cur_mem[i]); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++; if ({pause, ff_se, ff_dir, ram_se, ram_sd, dout_valid, din_ready, busy, done} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {pause, ff_se, ff_dir, ram_se, ram_sd, dout_valid, din_ready, busy, done});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_release: cmd_ready=%b busy=%b want 1/0", cmd_ready, busy); end
  endtask

  task automatic test_dump_basic;
    load_model(0, 64'd0);
    run_checkpoint(1'b0, 0, 0);
    check_counts("dump", 3, 12, 0, NW, 18);
    check_target("dump_intact");
  endtask

  task automatic test_dump_backpressure;
    load_model(0, 64'd0);
    run_checkpoint(1'b0, 1, 0);
    check_counts("dump_bp", 3, 12, 0, NW, 0);
  endtask

  task automatic test_restore_basic;
    for (int i = 0; i < NW; i++) stream[i] = 64'(i + 1);
    run_checkpoint(1'b1, 0, 0);
    check_counts("restore", 3, 11, 1, 0, 16);
    for (int i = 0; i < FFW; i++) cur_ff[i]  = stream[i];
    for (int i = 0; i < MW; i++)  cur_mem[i] = stream[FFW + i];
    check_target("restore");
  endtask

  task automatic test_restore_gaps;
    for (int i = 0; i < NW; i++) stream[i] = {$urandom, $urandom};
    run_checkpoint(1'b1, 0, 1);
    check_counts("restore_gap", 3, 11, 1, 0, 0);
    for (int i = 0; i < FFW; i++) cur_ff[i]  = stream[i];
    for (int i = 0; i < MW; i++)  cur_mem[i] = stream[FFW + i];
    check_target("restore_gap");
  endtask

  task automatic test_round_trip;
    logic [63:0] orig_ff [FFW];
    logic [63:0] orig_mem [MW];
    load_model(0, 64'd0);
    orig_ff  = cur_ff;
    orig_mem = cur_mem;
    run_checkpoint(1'b0, 1, 0);
    stream = got;
    load_model(1, 64'hFEED_0000_0000_0000);
    run_checkpoint(1'b1, 0, 1);
    cur_ff  = orig_ff;
    cur_mem = orig_mem;
    check_target("round_trip");
  endtask

  task automatic test_reset_mid_scan;
    int nr = 0;
    bit reached = 0;
    load_model(1, 64'h0000_0000_0000_0100);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b0; dout_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 60 && !reached; cyc++) begin
      #1;
      if (ram_se) nr++;
      if (nr >= 6) reached = 1;
      else @(negedge clk);
    end
    total++; if (!reached) begin bad++; $display("FAIL mid_reset_reach: ram_se seen %0d want 6", nr); end
    rst = 1'b1;
    #1;
    total++; if ({pause, ff_se, ff_dir, ram_se, ram_sd, dout_valid, din_ready, busy, done} !== 9'd0) begin
      bad++; $display("FAIL mid_reset_outputs: got %b want 0", {pause, ff_se, ff_dir, ram_se, ram_sd, dout_valid, din_ready, busy, done});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++; if (ff_se !== 1'b0 || ram_se !== 1'b0) begin bad++; $display("FAIL mid_reset_se: ff_se=%b ram_se=%b want 0/0", ff_se, ram_se); end
    end
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b want 1", cmd_ready); end
    run_checkpoint(1'b0, 0, 0);
    check_counts("after_reset", 3, 12, 0, NW, 18);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
    dout_ready = 1'b1; din_valid = 1'b0; din_data = '0;
    test_reset;
    test_dump_basic;
    test_dump_backpressure;
    test_restore_basic;
    test_restore_gaps;
    test_round_trip;
    test_reset_mid_scan;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
